dlfloat_stream_master: RTL

DLFLOAT_STREAM_MASTER -- requirements
Module: dlfloat_stream_master

---
 rtl/dlfloat_stream_master.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/dlfloat_stream_master.sv
// dlfloat_stream_master: time-multiplexes DL-float operand pairs onto a MAC input bus and reassembles its byte-serial results.
//
// Optional feature: define DLMAC_RESULT_FIFO_EN to buffer results in a 4-entry FIFO.
//
// Parameters
//   RX_PHASE    value of ph at the edge that captures the result MSB byte
//   SKIP_WORDS  assembled words discarded after reset while the MAC pipeline fills
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   op_a, op_b      operand pair, accepted when op_valid & op_ready
//   op_valid        operand pair offered
//   op_ready        high on ph==0 cycles; the pair is taken on that edge
//   bus_data        registered operand word: A while ph==1, B while ph==0
//   res_byte        MAC result byte stream, MSB then LSB
//   res_data        reassembled result word
//   res_valid       res_data valid
//   res_ready       consumer accept (FIFO build only)
//   overflow        sticky result-drop flag (FIFO build only, else 0)
//   pair_count      operand pairs accepted, wraps mod 2^16
module dlfloat_stream_master #(
    parameter int RX_PHASE   = 0,
    parameter int SKIP_WORDS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    input  logic        op_valid,
    output logic        op_ready,
    output logic [15:0] bus_data,
    input  logic [7:0]  res_byte,
    output logic [15:0] res_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        overflow,
    output logic [15:0] pair_count
);
    localparam int   SW  = (SKIP_WORDS < 1) ? 1 : $clog2(SKIP_WORDS + 1);
    localparam logic RXP = RX_PHASE[0];

    logic          ph;
    logic [15:0]   b_hold;
    logic [15:0]   pair_cnt;
    logic [7:0]    msb_hold;
    logic [SW-1:0] skip_cnt;
    logic          lsb_edge;
    logic          skip_done;
    logic          deliver;
    logic [15:0]   word;

    assign op_ready   = ~ph;
    assign pair_count = pair_cnt;
    assign lsb_edge   = ph != RXP;
    assign word       = {msb_hold, res_byte};
    assign skip_done  = skip_cnt == SW'(SKIP_WORDS);
    assign deliver    = lsb_edge & skip_done;

    // A bubble loads zero into both slots so the MAC sees a zero product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph       <= 1'b0;
            bus_data <= '0;
            b_hold   <= '0;
            pair_cnt <= '0;
        end else begin
            ph <= ~ph;
            if (!ph) begin
                bus_data <= op_valid ? op_a : '0;
                b_hold   <= op_valid ? op_b : '0;
                if (op_valid)
                    pair_cnt <= pair_cnt + 16'd1;
            end else begin
                bus_data <= b_hold;
            end
        end
    end

    // Skip counter saturates at SKIP_WORDS, after which every assembled word is delivered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msb_hold <= '0;
            skip_cnt <= '0;
        end else if (!lsb_edge) begin
            msb_hold <= res_byte;
        end else if (!skip_done) begin
            skip_cnt <= skip_cnt + SW'(1);
        end
    end

`ifdef DLMAC_RESULT_FIFO_EN
    logic [15:0] mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic        full;
    logic        pop;
    logic        do_push;

    assign full      = count[2];
    assign res_valid = count != 3'd0;
    assign res_data  = res_valid ? mem[rd_ptr] : '0;
    assign pop       = res_valid & res_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push   = deliver & (~full | pop);

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 2'd1;
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b0, do_push} - {2'b0, pop};
            if (deliver & full & ~pop)
                overflow <= 1'b1;
        end
    end
`else
    logic unused_res_ready;

    assign unused_res_ready = res_ready;
    assign overflow         = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data  <= '0;
            res_valid <= 1'b0;
        end else begin
            res_valid <= deliver;
            if (deliver)
                res_data <= word;
        end
    end
`endif

endmodule
